// File: rtl/add_seq_ctrl_pkg.sv
// Shared adder definitions: nibble slice width and controller state encodings.
// Imported by add_seq_ctrl and by the add4pg nibble slice.
`ifndef ADD_SEQ_CTRL_PKG_SV
`define ADD_SEQ_CTRL_PKG_SV
package add_seq_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`endif

// File: rtl/add_seq_ctrl_add4pg.sv
// add4pg: 4-bit adder slice with group generate/propagate.
//   a, b  : nibble operands
//   cin   : carry into bit 0
//   s     : nibble sum
//   gg    : group generate (carry out regardless of cin)
//   pg    : group propagate (carry out equals cin)
module add4pg
  import add_seq_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             gg,
  output logic             pg
);

  logic [NIB_W-1:0] g, p;
  logic [NIB_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s  = p ^ c[NIB_W-1:0];
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: nibble-serial add/subtract controller.
// Accepts an operand pair on in_valid/in_ready, runs one nibble per cycle
// through a single add4pg slice, then presents sum/cout/ovf/zero with
// out_valid until out_ready.
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : abort any operation in flight
//   in_valid/in_ready : request handshake; a, b, sub are the request
//   out_valid/out_ready : result handshake; sum, cout, ovf, zero are the result
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N    = WIDTH / NIB_W;
  localparam int IDXW = $clog2(N);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, work_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;

  logic [NIB_W-1:0] s4;
  logic             gg, pg, c_nxt;
  logic [WIDTH-1:0] res_d;
  logic             accept, run, last;

  add4pg u_slice (
    .a   (a_q[idx_q*NIB_W +: NIB_W]),
    .b   (b_q[idx_q*NIB_W +: NIB_W]),
    .cin (carry_q),
    .s   (s4),
    .gg  (gg),
    .pg  (pg)
  );

  assign c_nxt  = gg | (pg & carry_q);
  assign accept = (state_q == ST_IDLE) && in_valid && !flush;
  assign run    = (state_q == ST_RUN) && !flush;
  assign last   = (idx_q == LAST);

  // Working result with the current nibble merged in; on the last nibble
  // this is the complete sum, so flags are derived from it directly.
  always_comb begin
    res_d = work_q;
    res_d[idx_q*NIB_W +: NIB_W] = s4;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        idx_q <= '0;
      end else if (accept) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub;        // +1 completes the two's complement of b
        idx_q   <= '0;
      end else if (run) begin
        work_q  <= res_d;
        carry_q <= c_nxt;
        idx_q   <= last ? '0 : idx_q + 1'b1;
        if (last) begin
          sum_q  <= res_d;
          cout_q <= c_nxt;
          ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_q <= (res_d == '0);
        end
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
module tb_add_seq_ctrl;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cout, ovf, zero;

  exp_t q[$];
  int   n_vec = 0, n_mis = 0;
  logic [W-1:0] last_sum = '0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t         e;
    logic [W-1:0] yy;
    logic [W:0]   r;
    yy  = s ? ~y : y;
    r   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    e.s = r[W-1:0];
    e.c = r[W];
    e.v = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    e.z = (r[W-1:0] == '0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one request; returns the number of edges until out_valid.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input bit keep_valid, input bit scramble, output int lat);
    chk("in_ready_idle", in_ready, 1);
    a = x; b = y; sub = s; in_valid = 1'b1;
    step();
    q.push_back(model(x, y, s));
    in_valid = keep_valid;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); end
      step();
      lat++;
      if (lat == 1) chk("in_ready_run", in_ready, 0);
    end
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input int hold, input bit scramble);
    int   lat;
    exp_t e;
    start_op(x, y, s, hold > 0, scramble, lat);
    chk("latency", lat, 8);
    e = q[0];
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_sum", sum, e.s);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (q.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = q.pop_front();
      chk("sum", sum, e.s);
      chk("cout", cout, e.c);
      chk("ovf", ovf, e.v);
      chk("zero", zero, e.z);
      last_sum = e.s;
    end
    step();
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf, zero}, 0);
    rst_n = 1'b1;
    step();

    do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0, 0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 0);
    do_op(32'h0000_0003, 32'h0000_0005, 1'b1, 0, 0);
    // stall in DONE with in_valid asserted
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 5, 0);
    // operands wiggle throughout RUN
    do_op(32'hDEAD_BEEF, 32'h1111_2222, 1'b1, 0, 1);

    // flush on the edge that processes nibble 3
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    for (int i = 0; i < 10; i++) step();
    chk("flush_no_result", out_valid, 0);
    chk("flush_keeps_sum", sum, last_sum);
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 0);

    // reset while in DONE
    start_op(32'h4444_4444, 32'h3333_3333, 1'b0, 0, 0, lat);
    chk("rst_done_lat", lat, 8);
    void'(q.pop_back());
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstd_valid", out_valid, 0);
    chk("rstd_ready", in_ready, 1);
    chk("rstd_sum", sum, 0);
    for (int i = 0; i < 10; i++) step();
    chk("rstd_no_result", out_valid, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0);

    for (int i = 0; i < 6; i++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), i % 3, i[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-005 SHALL have port in_valid  input  1  request carries a valid operand pair.
REQ-006 SHALL have port in_ready  output  1  controller can accept a request.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 selects a+b; 1 selects a-b.
REQ-010 SHALL have port out_valid  output  1  result fields are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-015 SHALL have port zero  output  1  sum equals 0.

Function
REQ-016 SHALL be a three-state FSM: IDLE, RUN and DONE.
REQ-017 SHALL assert in_ready only in IDLE.
REQ-018 SHALL accept a request on an edge with in_valid and in_ready both high, then enter RUN.
REQ-019 SHALL, on acceptance, capture a, b (inverted when sub=1) and sub, and set the nibble carry to sub.
REQ-020 SHALL ignore changes on a, b and sub after acceptance.
REQ-021 SHALL process one nibble per RUN cycle, index k from 0 to N-1 (N = WIDTH/4), through a single shared 4-bit slice.
REQ-022 SHALL register sum nibble k, and the next carry = GG | (PG & carry), on each RUN edge.
REQ-023 SHALL move to DONE on the edge that processes nibble N-1, so out_valid rises exactly N edges after the accepting edge (8 for WIDTH=32).
REQ-024 SHALL set cout to the final carry.
REQ-025 SHALL set ovf to 1 exactly when the captured a MSB equals the effective b MSB and the sum MSB differs from it.
REQ-026 SHALL set zero to 1 exactly when sum is 0.
REQ-027 SHALL hold out_valid, sum, cout, ovf and zero stable in DONE until out_ready is high.
REQ-028 SHALL return to IDLE on the edge where out_valid and out_ready are both high; the next acceptance is possible no earlier than the following edge.
REQ-029 SHALL ignore in_valid in RUN and DONE.
REQ-030 SHALL, when flush is high on any edge, go to IDLE and clear out_valid without producing a result; flush in IDLE has no effect.
REQ-031 SHALL give flush priority over acceptance and over the out handshake when they coincide on the same edge.
REQ-032 SHALL retain the last result fields until the next completion or reset; only out_valid qualifies them.

Reset
REQ-033 SHALL, on an edge with rst_n low, force IDLE, out_valid=0, sum=0, cout=0, ovf=0, zero=0, nibble index=0 and carry=0.
REQ-034 SHALL give rst_n priority over flush and all handshakes.
REQ-035 SHALL let reset in RUN or DONE discard the operation, with no out_valid afterwards.
REQ-036 SHALL have in_ready=1 from the first reset edge onward.

Structure
REQ-037 SHALL keep the FSM state encodings and the nibble width constant (4) in the shared adder defines header, guarded by include guards.
REQ-038 SHALL instantiate exactly one add4pg as its only sub-module; all carry chaining between nibbles is sequential in this block.
REQ-039 SHALL use an index counter of $clog2(N) bits.

Verification
REQ-040 SHALL cover: a=0x00000001, b=0xFFFFFFFF, sub=0 -> sum=0x00000000, cout=1, ovf=0, zero=1, out_valid exactly 8 edges after acceptance.
REQ-041 SHALL cover: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1, zero=0.
REQ-042 SHALL cover: a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1; and a=0x00000003, b=0x00000005, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-043 SHALL cover: out_ready held low 5 cycles in DONE with in_valid high -> outputs stable, in_ready=0, no second acceptance; out_ready=1 -> IDLE next edge.
REQ-044 SHALL cover: a and b changed every cycle during RUN -> result equals the captured operands.
REQ-045 SHALL cover: flush at RUN nibble 3, and separately rst_n low in DONE -> IDLE on the next edge, no out_valid, and a new request completes correctly.
